// File: rtl/cell_button_conditioner.sv
// Nine-cell button front end: 2-flop synchroniser, per-bit debounce and a press arbiter that emits
// at most one single-cycle pulse per physical press. Define CELL_GAME_OVER_LOCK_EN to add game_over.
module cell_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] raw_btn,
`ifdef CELL_GAME_OVER_LOCK_EN
    input  logic       game_over,
`endif
    output logic [8:0] btn_pulse,
    output logic       press_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT_RELEASE
    } state_t;

    logic [8:0] sync1_reg;
    logic [8:0] sync2_reg;
    logic [8:0] stable;
    logic [8:0] stable_d_reg;
    logic [8:0] req;
    logic       one_hot;
    logic       lock;
    state_t     state_reg;
    logic [1:0] settle_reg;
    logic       post_reset_reg;

`ifdef CELL_GAME_OVER_LOCK_EN
    assign lock = game_over;
`else
    assign lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg    <= 9'd0;
            sync2_reg    <= 9'd0;
            stable_d_reg <= 9'd0;
        end else begin
            sync1_reg    <= raw_btn;
            sync2_reg    <= sync1_reg;
            stable_d_reg <= stable;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_MAX) begin
                    stable_reg <= sync2_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    assign req     = stable & ~stable_d_reg;
    assign one_hot = ((req & (req - 9'd1)) == 9'd0);
    assign busy    = (state_reg != IDLE);

    // Right after reset the synchroniser still holds zeros, so stable==0 says nothing about the
    // real buttons. The first exit from WAIT_RELEASE therefore waits until sync2 carries post-reset
    // samples and shows no button pressed; a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= WAIT_RELEASE;
            btn_pulse      <= 9'd0;
            press_err      <= 1'b0;
            settle_reg     <= 2'd0;
            post_reset_reg <= 1'b1;
        end else begin
            btn_pulse <= 9'd0;
            press_err <= 1'b0;
            if (settle_reg != 2'd2) begin
                settle_reg <= settle_reg + 2'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (req != 9'd0) begin
                        state_reg <= WAIT_RELEASE;
                        if (!lock) begin
                            if (one_hot) begin
                                btn_pulse <= req;
                            end else begin
                                press_err <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if ((stable == 9'd0) &&
                        (!post_reset_reg || ((settle_reg == 2'd2) && (sync2_reg == 9'd0)))) begin
                        state_reg      <= IDLE;
                        post_reset_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= WAIT_RELEASE;
                end
            endcase
        end
    end

endmodule
